// File: rtl/jimbo_mem_responder.sv
// External-memory target for the 4-bit CPU: nibble RAM plus two MMIO nibbles,
// with a host load port that fills RAM while the CPU is held in reset.
module jimbo_mem_responder #(
  parameter int          AW       = 8,
  parameter logic [11:0] OUT_ADDR = 12'hFFF,
  parameter logic [11:0] IN_ADDR  = 12'hFFE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] bus_addr,
  input  logic        bus_data_rw,
  input  logic [3:0]  bus_wdata,
  output logic [3:0]  bus_rdata,
  output logic        bus_rdata_oe,
  output logic        cpu_rst_n,
  input  logic        load_en,
  input  logic        load_valid,
  input  logic [3:0]  load_data,
  output logic        load_ready,
  input  logic [3:0]  gpio_in,
  output logic [3:0]  gpio_out
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] ptr, ptr_nxt;
  logic          load_en_q;
  logic          load_rise;
  logic [3:0]    gpio_in_p0, gpio_in_p1;
  logic [3:0]    ram [0:(1<<AW)-1];

  logic          bus_act;
  logic          ram_hit, out_hit, in_hit;
  logic          ram_we;
  logic [AW-1:0] ram_waddr;
  logic [3:0]    ram_wdata;
  logic [3:0]    rd_val;

  assign load_rise = load_en & ~load_en_q;

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    case (state)
      IDLE: begin
        if (load_en) begin
          state_nxt = LOAD;
          ptr_nxt   = '0;
        end else begin
          state_nxt = RUN;
        end
      end
      LOAD: begin
        if (load_valid) ptr_nxt = ptr + AW'(1);
        if (!load_en)   state_nxt = RUN;
      end
      RUN: begin
        if (load_rise) begin
          state_nxt = LOAD;
          ptr_nxt   = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The cycle that requests a reload already belongs to the loader, so CPU
  // accesses are dropped from that cycle on.
  assign bus_act = (state == RUN) && !load_rise;
  assign ram_hit = (bus_addr >> AW) == 12'd0;
  assign out_hit = (bus_addr == OUT_ADDR);
  assign in_hit  = (bus_addr == IN_ADDR);

  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = ptr;
    ram_wdata = load_data;
    if (state == LOAD && load_valid) begin
      ram_we = 1'b1;
    end else if (bus_act && bus_data_rw && ram_hit) begin
      ram_we    = 1'b1;
      ram_waddr = bus_addr[AW-1:0];
      ram_wdata = bus_wdata;
    end
  end

  always_comb begin
    rd_val = 4'h0;
    if (ram_hit)      rd_val = ram[bus_addr[AW-1:0]];
    else if (out_hit) rd_val = gpio_out;
    else if (in_hit)  rd_val = gpio_in_p1;
  end

  always_ff @(posedge clk) begin
    if (ram_we) ram[ram_waddr] <= ram_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= '0;
      load_en_q  <= 1'b0;
      cpu_rst_n  <= 1'b0;
      gpio_out   <= 4'h0;
      gpio_in_p0 <= 4'h0;
      gpio_in_p1 <= 4'h0;
      bus_rdata  <= 4'h0;
    end else begin
      state      <= state_nxt;
      ptr        <= ptr_nxt;
      load_en_q  <= load_en;
      // Releases one cycle after RUN entry, but drops on the same edge RUN is left.
      cpu_rst_n  <= (state == RUN) && (state_nxt == RUN);
      gpio_in_p0 <= gpio_in;
      gpio_in_p1 <= gpio_in_p0;
      if (bus_act && bus_data_rw && out_hit) gpio_out <= bus_wdata;
      if (bus_act && !bus_data_rw)           bus_rdata <= rd_val;
    end
  end

  assign load_ready   = (state == LOAD);
  assign bus_rdata_oe = (state == RUN) && !bus_data_rw;

endmodule
